// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multiply/divide unit: opcodes, FSM states and op decode helpers.
// The decoder and hazard unit import the same package so the encodings live in one place.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate: y = neg ? -a : a.
// Used both to take operand magnitudes and to restore result signs.
module mdu_abs_neg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO; one result bit per cycle over WIDTH cycles.
// Signed ops run on magnitudes and fix the sign of the result on the final iteration edge.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  mdu_state_e         state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   opnd;
  logic               neg_q, neg_r, div_zero;

  logic               launch, last, finish, signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, shifted, diff;
  logic               qbit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy      = (state != ST_IDLE);
  assign signed_op = is_signed_op(op);
  assign launch    = start && !abort && (state == ST_IDLE);
  assign last      = (cnt == CNT_W'(WIDTH - 1));

  mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.a(srca), .neg(signed_op & srca[WIDTH-1]), .y(abs_a));
  mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.a(srcb), .neg(signed_op & srcb[WIDTH-1]), .y(abs_b));

  // NOTE: state register only; next-state logic stays combinational below.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    finish    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (launch && is_mul_op(op))      state_nxt = ST_MUL;
        else if (launch && is_div_op(op)) state_nxt = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (last) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // acc holds {partial product, remaining multiplier} for MUL and {remainder, quotient} for DIV.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, opnd};
    qbit    = !diff[WIDTH];
    if (state == ST_MUL) acc_nxt = {sum, acc[WIDTH-1:1]};
    else acc_nxt = {(qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]), acc[WIDTH-2:0], qbit};
  end

  mdu_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (.a(acc_nxt), .neg(neg_q), .y(prod_fix));
  mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (.a(acc_nxt[WIDTH-1:0]), .neg(neg_q), .y(quo_fix));
  mdu_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (.a(acc_nxt[2*WIDTH-1:WIDTH]), .neg(neg_r), .y(rem_fix));

  // NOTE: the datapath registers are reset too, so an op cut short by reset leaves no stale state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= finish;
      if (launch) begin
        if (is_mul_op(op) || is_div_op(op)) begin
          cnt      <= '0;
          neg_q    <= signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
          neg_r    <= signed_op & srca[WIDTH-1];
          div_zero <= (srcb == '0);
          opnd     <= is_mul_op(op) ? abs_a : abs_b;
          acc      <= {{WIDTH{1'b0}}, (is_mul_op(op) ? abs_b : abs_a)};
        end else if (op == MDU_MTHI) begin
          hi <= srca;
        end else if (op == MDU_MTLO) begin
          lo <= srca;
        end
      end else if (busy && !abort) begin
        acc <= acc_nxt;
        cnt <= cnt + CNT_W'(1);
        if (finish && state == ST_MUL) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else if (finish) begin
          // Divide by zero: the remainder path already yields srca; only the quotient is forced.
          hi <= rem_fix;
          lo <= div_zero ? '1 : quo_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: a cycle-level reference model compared every cycle,
// plus hand-computed literal results for each directed operation.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] srca = '0, srcb = '0;
  logic        abort = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .abort(abort), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a mult/div op as {hi, lo}, straight from the arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (mop)
      MDU_MULT:  return sa * sb;
      MDU_MULTU: return ua * ub;
      MDU_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {(a % b), (a / b)};
      end
    endcase
  endfunction

  // Reference timeline: cycles left in flight, pending result, architectural HI/LO.
  int          m_rem = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_rem != 0) begin
        if (abort) m_rem <= 0;
        else begin
          m_rem <= m_rem - 1;
          if (m_rem == 1) begin
            m_hi <= m_res[63:32]; m_lo <= m_res[31:0]; m_done <= 1'b1;
          end
        end
      end else if (start && !abort) begin
        if (op <= 3'b011) begin
          m_rem <= 32;
          m_res <= model(op, srca, srcb);
        end else if (op == MDU_MTHI) m_hi <= srca;
        else if (op == MDU_MTLO) m_lo <= srca;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_rem != 0));
      check("done", 64'(done), 64'(m_done));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic pulse(input logic [2:0] p_op, input logic [31:0] a, input logic [31:0] b,
                       input logic p_abort);
    @(posedge clk); #1;
    start = 1'b1; op = p_op; srca = a; srcb = b; abort = p_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  // Launch an op, optionally inject a stray start while busy, then check the literal result.
  task automatic run_op(input string name, input logic [2:0] p_op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inj);
    int  bc;
    bit  seen;
    bc = 0;
    seen = 1'b0;
    pulse(p_op, a, b, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
      if (busy) bc++;
      if (bc == inj) begin
        start = 1'b1; op = MDU_MTHI; srca = 32'hDEAD_BEEF; srcb = 32'h1;
      end else start = 1'b0;
    end
    start = 1'b0;
    check({name, " done seen"}, 64'(seen), 64'd1);
    check({name, " busy cycles"}, 64'(bc), 64'd32);
    check({name, " hi"}, 64'(hi), 64'(exp_hi));
    check({name, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    bit saw_done;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset hi", 64'(hi), 64'd0);

    run_op("mult -1*2", MDU_MULT, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, -1);
    run_op("mult min*min", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, -1);
    run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
    run_op("div 7/-2", MDU_DIV, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, -1);
    run_op("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1);
    run_op("divu 7/0", MDU_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, -1);
    run_op("div -7/0", MDU_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
    run_op("div min/-1", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1);
    run_op("divu stray start", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);

    // MTHI then MTLO on back-to-back idle cycles.
    @(posedge clk); #1;
    start = 1'b1; op = MDU_MTHI; srca = 32'h1234;
    @(posedge clk); #1;
    op = MDU_MTLO; srca = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("mthi", 64'(hi), 64'h1234);
    check("mtlo", 64'(lo), 64'h5678);

    // NOP opcode and start+abort while idle are both discarded.
    pulse(3'b110, 32'hAAAA, 32'h1, 1'b0);
    pulse(MDU_MTHI, 32'hBEEF, 32'h1, 1'b1);
    pulse(MDU_MULT, 32'h3, 32'h5, 1'b1);
    @(negedge clk);
    check("discarded busy", 64'(busy), 64'd0);
    check("discarded hi", 64'(hi), 64'h1234);

    // Abort on iteration edge E10.
    pulse(MDU_MULT, 32'h3, 32'h5, 1'b0);
    repeat (8) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi", 64'(hi), 64'h1234);
    check("abort lo", 64'(lo), 64'h5678);
    saw_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort no done", 64'(saw_done), 64'd0);

    // Reset in the middle of an operation.
    pulse(MDU_MULT, 32'h3, 32'h5, 1'b0);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("reset mid busy", 64'(busy), 64'd0);
    check("reset mid done", 64'(done), 64'd0);
    check("reset mid hi", 64'(hi), 64'd0);
    check("reset mid lo", 64'(lo), 64'd0);

    run_op("mult after reset", MDU_MULT, 32'h3, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, -1);
    repeat (2) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
